contrast_sequencer: RTL and testbench
=====================================

Name: contrast_sequencer

Overview:
- Frame-level controller for the min/max contrast statistics path.
- Counts incoming pixels and lines, and opens a programmable active window so that statistics cover only the useful sensor area.
- At end of frame, issues the one-cycle frame strobe that makes the statistics block latch MIN/MAX.
- Then runs a serial divider to produce an 8-bit Q4.4 contrast gain with a valid handshake for the video output stage.

Parameters:
ADC_W, 14, width of MIN/MAX sample values
COLS, 384, pixels per line (counter wrap)
ROWS, 288, lines per frame
WIN_X0, 8, first active column (inclusive)
WIN_X1, 375, last active column (inclusive)
WIN_Y0, 4, first active line (inclusive)
WIN_Y1, 283, last active line (inclusive)
TARGET, 255, output span the stretched range maps to
STAT_LAT, 2, cycles between FRAME_PULSE and MIN/MAX being stable

Ports:
CLK100  in  1  system clock
RESET  in  1  async active-high reset
FRAME_START  in  1  one-cycle pulse, first pixel of frame follows
PIX_VALID  in  1  one-cycle strobe per ADC sample
STAT_MIN  in  ADC_W  latched frame minimum from statistics block
STAT_MAX  in  ADC_W  latched frame maximum from statistics block
WIN_ENABLE  out  1  high while current pixel is inside window (qualifies statistics)
FRAME_PULSE  out  1  one-cycle frame-end strobe to statistics block
GAIN  out  8  Q4.4 contrast gain
GAIN_VALID  out  1  one-cycle pulse when GAIN updates
GAIN_ACK  in  1  consumer acknowledge; clears PENDING
PENDING  out  1  high from GAIN_VALID until GAIN_ACK
OVERRUN  out  1  sticky: a frame ended while divide was busy; cleared by RESET only

Behaviour:
- Reset: RESET is asynchronous, active-high; clock is CLK100. On reset, all counters are 0, FSM is IDLE, and every output is 0 except GAIN = 8'h10 (unity).
- Pixel counter: col increments on PIX_VALID. When col = COLS-1 it wraps to 0 and row increments. FRAME_START forces col = row = 0, overriding PIX_VALID that cycle.
- WIN_ENABLE: combinational from the registered col/row and PIX_VALID: PIX_VALID & WIN_X0<=col<=WIN_X1 & WIN_Y0<=row<=WIN_Y1.
- Frame end: the PIX_VALID with col = COLS-1 and row = ROWS-1 makes FRAME_PULSE high on the next cycle, for exactly one cycle.
  - Afterwards the counter saturates at row = ROWS and further PIX_VALID is ignored until FRAME_START.
- FRAME_START arriving before frame end: the frame is discarded, no FRAME_PULSE is issued, and counting restarts.
- Calc FSM states: IDLE -> SETTLE -> DIVIDE -> UPDATE -> IDLE.
  - IDLE: waits for FRAME_PULSE.
  - SETTLE: counts STAT_LAT cycles, then registers range = STAT_MAX - STAT_MIN (ADC_W bits). STAT_MAX < STAT_MIN is treated as range 0.
  - DIVIDE: restoring divider, one quotient bit per cycle, 12 cycles, computing q = (TARGET<<4)/range. range = 0 skips the divide and forces q = 255.
  - UPDATE: GAIN = min(q, 255); GAIN_VALID pulses; PENDING set.
- Latency: FRAME_PULSE to GAIN_VALID = STAT_LAT + 12 + 2 cycles (16 at defaults).
- FRAME_PULSE while state is not IDLE: OVERRUN set, FSM restarts at SETTLE with the new statistics, and the in-progress quotient is dropped.
- Handshake: GAIN_ACK clears PENDING.
  - A new GAIN_VALID while PENDING is still set overwrites GAIN, and PENDING stays high.
  - GAIN_ACK and UPDATE in the same cycle: UPDATE wins, PENDING = 1.
- Reset mid-divide: aborts immediately and GAIN returns to 8'h10.

Optional Feature:
CONTRAST_GAIN_IIR_EN
- Defined: in UPDATE, GAIN = (3*GAIN_old + min(q, 255) + 2) >> 2. Width 10 bits internally, result fits in 8 bits. Temporal smoothing adds no latency cycles.
- Undefined: GAIN = min(q, 255) directly.

Test Plan:
- Reset mid-DIVIDE -> GAIN = 8'h10, GAIN_VALID = 0, FSM IDLE next cycle, OVERRUN = 0.
- Full frame of 384x288 PIX_VALID strobes -> WIN_ENABLE asserted for exactly 368*280 = 103040 strobes; one FRAME_PULSE, 1 cycle after the last strobe.
- STAT_MIN = 1000, STAT_MAX = 1255 -> GAIN = 16 (4080/255), GAIN_VALID 16 cycles after FRAME_PULSE. Then STAT_MAX = 1100 -> GAIN = 40.
- STAT_MIN = STAT_MAX = 500 -> GAIN = 255; STAT_MAX = 400, STAT_MIN = 500 -> GAIN = 255.
- Second FRAME_PULSE forced 5 cycles into DIVIDE -> OVERRUN = 1, single GAIN_VALID carrying the second frame's result.
- GAIN_ACK in same cycle as UPDATE -> PENDING stays 1. ACK one cycle later -> PENDING = 0. With CONTRAST_GAIN_IIR_EN, q = 32 from GAIN = 16 -> GAIN = 20.

Source files
------------

// File: rtl/contrast_sequencer.sv
// Frame-level contrast controller: pixel/line counting, active window, frame-end strobe and
// serial Q4.4 gain divider with valid/ack handshake. Optional smoothing: CONTRAST_GAIN_IIR_EN.
module contrast_sequencer #(
    parameter int ADC_W    = 14,
    parameter int COLS     = 384,
    parameter int ROWS     = 288,
    parameter int WIN_X0   = 8,
    parameter int WIN_X1   = 375,
    parameter int WIN_Y0   = 4,
    parameter int WIN_Y1   = 283,
    parameter int TARGET   = 255,
    parameter int STAT_LAT = 2
) (
    input  logic             CLK100,
    input  logic             RESET,
    input  logic             FRAME_START,
    input  logic             PIX_VALID,
    input  logic [ADC_W-1:0] STAT_MIN,
    input  logic [ADC_W-1:0] STAT_MAX,
    output logic             WIN_ENABLE,
    output logic             FRAME_PULSE,
    output logic [7:0]       GAIN,
    output logic             GAIN_VALID,
    input  logic             GAIN_ACK,
    output logic             PENDING,
    output logic             OVERRUN
);
    localparam int COL_W = $clog2(COLS);
    localparam int ROW_W = $clog2(ROWS + 1);
    localparam int LAT_W = $clog2(STAT_LAT + 1);
    localparam int DIV_W = 12;
    localparam logic [DIV_W-1:0] DIVIDEND = DIV_W'(TARGET * 16);

    typedef enum logic [1:0] {IDLE, SETTLE, DIVIDE, UPDATE} state_t;

    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
    logic             frame_pulse;
    logic             last_pix, frame_done;

    state_t           state, state_next;
    logic [LAT_W-1:0] settle_cnt;
    logic [3:0]       bit_cnt;
    logic [ADC_W-1:0] range_r, range_calc, rem;
    logic [ADC_W:0]   rem_sh;
    logic             rem_ge, range_zero;
    logic [DIV_W-1:0] dvd, quo;
    logic [7:0]       gain_r, q_sat, gain_next;
    logic             gain_valid_r, pending_r, overrun_r;
    logic             start_calc, load_range, div_step, do_update;

    assign last_pix   = (col == COL_W'(COLS - 1)) && (row == ROW_W'(ROWS - 1));
    assign frame_done = (row == ROW_W'(ROWS));
    assign WIN_ENABLE = PIX_VALID && (int'(col) >= WIN_X0) && (int'(col) <= WIN_X1)
                        && (int'(row) >= WIN_Y0) && (int'(row) <= WIN_Y1);

    // Row saturates at ROWS after the last pixel so stray strobes cannot start a phantom frame.
    always_ff @(posedge CLK100 or posedge RESET) begin
        if (RESET) begin
            col         <= '0;
            row         <= '0;
            frame_pulse <= 1'b0;
        end else begin
            frame_pulse <= PIX_VALID && !FRAME_START && last_pix;
            if (FRAME_START) begin
                col <= '0;
                row <= '0;
            end else if (PIX_VALID && !frame_done) begin
                if (col == COL_W'(COLS - 1)) begin
                    col <= '0;
                    row <= row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
            end
        end
    end

    assign range_zero = (STAT_MAX <= STAT_MIN);
    assign range_calc = range_zero ? '0 : STAT_MAX - STAT_MIN;
    assign rem_sh     = {rem, dvd[DIV_W-1]};
    assign rem_ge     = (rem_sh >= {1'b0, range_r});
    assign q_sat      = (|quo[DIV_W-1:8]) ? 8'hFF : quo[7:0];

`ifdef CONTRAST_GAIN_IIR_EN
    logic [9:0] iir_sum;
    assign iir_sum   = {2'b0, gain_r} + {1'b0, gain_r, 1'b0} + {2'b0, q_sat} + 10'd2;
    assign gain_next = iir_sum[9:2];
`else
    assign gain_next = q_sat;
`endif

    always_ff @(posedge CLK100 or posedge RESET) begin
        if (RESET) state <= IDLE;
        else       state <= state_next;
    end

    // A new frame end always wins: the calculation in flight is abandoned.
    always_comb begin
        state_next = state;
        start_calc = 1'b0;
        load_range = 1'b0;
        div_step   = 1'b0;
        do_update  = 1'b0;
        case (state)
            IDLE: ;
            SETTLE: if (settle_cnt == LAT_W'(STAT_LAT - 1)) begin
                load_range = 1'b1;
                state_next = range_zero ? UPDATE : DIVIDE;
            end
            DIVIDE: begin
                div_step = 1'b1;
                if (bit_cnt == 4'(DIV_W - 1)) state_next = UPDATE;
            end
            UPDATE: begin
                do_update  = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        if (frame_pulse) begin
            start_calc = 1'b1;
            load_range = 1'b0;
            div_step   = 1'b0;
            do_update  = 1'b0;
            state_next = SETTLE;
        end
    end

    always_ff @(posedge CLK100 or posedge RESET) begin
        if (RESET) begin
            settle_cnt   <= '0;
            bit_cnt      <= '0;
            range_r      <= '0;
            rem          <= '0;
            dvd          <= '0;
            quo          <= '0;
            gain_r       <= 8'h10;
            gain_valid_r <= 1'b0;
            pending_r    <= 1'b0;
            overrun_r    <= 1'b0;
        end else begin
            gain_valid_r <= 1'b0;
            if (start_calc)          settle_cnt <= '0;
            else if (state == SETTLE) settle_cnt <= settle_cnt + 1'b1;
            if (load_range) begin
                range_r <= range_calc;
                rem     <= '0;
                dvd     <= DIVIDEND;
                bit_cnt <= '0;
                quo     <= range_zero ? DIV_W'(255) : '0;
            end else if (div_step) begin
                rem     <= rem_ge ? ADC_W'(rem_sh - {1'b0, range_r}) : rem_sh[ADC_W-1:0];
                quo     <= {quo[DIV_W-2:0], rem_ge};
                dvd     <= {dvd[DIV_W-2:0], 1'b0};
                bit_cnt <= bit_cnt + 1'b1;
            end
            if (do_update) begin
                gain_r       <= gain_next;
                gain_valid_r <= 1'b1;
                pending_r    <= 1'b1;
            end else if (GAIN_ACK) begin
                pending_r    <= 1'b0;
            end
            if (frame_pulse && state != IDLE) overrun_r <= 1'b1;
        end
    end

    assign FRAME_PULSE = frame_pulse;
    assign GAIN        = gain_r;
    assign GAIN_VALID  = gain_valid_r;
    assign PENDING     = pending_r;
    assign OVERRUN     = overrun_r;
endmodule

// File: tb/tb_contrast_sequencer.sv
// Bench for contrast_sequencer on a small sensor geometry: behavioural frame/gain model checked
// every cycle, plus directed literal pins for gain values, latency, handshake, overrun and reset.
module tb_contrast_sequencer;
    localparam int COLS = 4, ROWS = 3, X0 = 1, X1 = 2, Y0 = 1, Y1 = 1;
    localparam int N = COLS * ROWS;
    localparam int STAT_LAT = 2, TARGET = 255;
`ifdef CONTRAST_GAIN_IIR_EN
    localparam bit IIR = 1'b1;
`else
    localparam bit IIR = 1'b0;
`endif

    logic        clk, rst, fs, pv, ack;
    logic [13:0] smin, smax;
    logic        win, fp, gv, pend, ovr;
    logic [7:0]  gain;

    int checks = 0, errors = 0, win_cnt = 0;

    contrast_sequencer #(
        .ADC_W(14), .COLS(COLS), .ROWS(ROWS), .WIN_X0(X0), .WIN_X1(X1),
        .WIN_Y0(Y0), .WIN_Y1(Y1), .TARGET(TARGET), .STAT_LAT(STAT_LAT)
    ) dut (
        .CLK100(clk), .RESET(rst), .FRAME_START(fs), .PIX_VALID(pv),
        .STAT_MIN(smin), .STAT_MAX(smax), .WIN_ENABLE(win), .FRAME_PULSE(fp),
        .GAIN(gain), .GAIN_VALID(gv), .GAIN_ACK(ack), .PENDING(pend), .OVERRUN(ovr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    function automatic int next_gain(input int q, input int old);
        int qs;
        qs = (q > 255) ? 255 : q;
        return IIR ? (3 * old + qs + 2) >> 2 : qs;
    endfunction

    // Model: frame position is a strobe index k; a gain job is described by its start cycle
    // and, once the statistics are sampled, the cycle its result must appear.
    int     k = 0, gain_m = 16, job_start, valid_at, job_q, rng;
    bit     fp_m = 0, pend_m = 0, ovr_m = 0, job_on = 0, known = 0, exp_gv, exp_win;
    longint cyc = 0;

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            k = 0; fp_m = 0; gain_m = 16; pend_m = 0; ovr_m = 0; job_on = 0; known = 0;
            exp_win = pv && (0 >= X0) && (0 >= Y0);
            chk("rst_win", win, exp_win);
            chk("rst_fp", fp, 0);
            chk("rst_gv", gv, 0);
            chk("rst_gain", gain, 16);
            chk("rst_pend", pend, 0);
            chk("rst_ovr", ovr, 0);
        end else begin
            exp_gv = 0;
            if (job_on && known && cyc == longint'(valid_at)) begin
                exp_gv = 1; gain_m = next_gain(job_q, gain_m); pend_m = 1; job_on = 0;
            end
            exp_win = pv && k < N && (k % COLS) >= X0 && (k % COLS) <= X1
                      && (k / COLS) >= Y0 && (k / COLS) <= Y1;
            if (win) win_cnt++;
            chk("win", win, exp_win);
            chk("frame_pulse", fp, fp_m);
            chk("gain_valid", gv, exp_gv);
            chk("gain", gain, gain_m);
            chk("pending", pend, pend_m);
            chk("overrun", ovr, ovr_m);
            if (ack) pend_m = 0;
            if (fp_m) begin
                if (job_on && (!known || cyc < longint'(valid_at))) ovr_m = 1;
                job_on = 1; known = 0; job_start = int'(cyc);
            end else if (job_on && !known && cyc == longint'(job_start + STAT_LAT)) begin
                rng      = (int'(smax) > int'(smin)) ? int'(smax) - int'(smin) : 0;
                job_q    = (rng == 0) ? 255 : (TARGET * 16) / rng;
                valid_at = int'(cyc) + ((rng == 0) ? 2 : 14);
                known    = 1;
            end
            fp_m = pv && !fs && k == N - 1;
            if (fs) k = 0;
            else if (pv && k < N) k++;
        end
    end

    task automatic drive(input bit f, input bit p, input bit a);
        @(posedge clk);
        #1;
        fs = f; pv = p; ack = a;
    endtask

    function automatic bit rbit(input bit en);
        return en && ($urandom_range(3, 0) == 0);
    endfunction

    task automatic frame(input int ns, input int gap_max, input bit rnd);
        int gaps;
        drive(1'b1, rnd ? 1'($urandom_range(1, 0)) : 1'b0, rbit(rnd));
        for (int i = 0; i < ns; i++) begin
            gaps = $urandom_range(gap_max, 0);
            repeat (gaps) drive(1'b0, 1'b0, rbit(rnd));
            drive(1'b0, 1'b1, rbit(rnd));
        end
    endtask

    task automatic run_gain(input string nm, input int mn, input int mx, input int gap,
                            input int exp_gain, input int exp_lat);
        int n, lat;
        smin = 14'(mn); smax = 14'(mx);
        frame(N, gap, 1'b0);
        n = -1000; lat = -1;
        drive(1'b0, 1'b0, 1'b0);
        chk({nm, "_fp_after_last"}, fp, 1);
        for (int i = 0; i < 40; i++) begin
            if (fp) n = 0; else n++;
            if (gv) begin lat = n; break; end
            drive(1'b0, 1'b0, 1'b0);
        end
        chk({nm, "_lat"}, lat, exp_lat);
        chk({nm, "_gain"}, gain, exp_gain);
    endtask

    initial begin
        int n, lat, gv_cnt, fp_cnt, mn, mx;
        rst = 1'b1; fs = 1'b0; pv = 1'b0; ack = 1'b0; smin = '0; smax = '0;
        #2;
        chk("por_gain", gain, 16);
        chk("por_gv", gv, 0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Window coverage and single frame-end strobe over one frame with gaps.
        win_cnt = 0;
        run_gain("r255", 1000, 1255, 2, 16, 16);
        chk("win_count", win_cnt, 2);
        run_gain("r127", 1000, 1127, 0, IIR ? 20 : 32, 16);
        run_gain("r100", 1000, 1100, 0, IIR ? 25 : 40, 16);
        run_gain("req", 500, 500, 0, IIR ? 83 : 255, 4);
        run_gain("rneg", 500, 400, 0, IIR ? 126 : 255, 4);

        // ACK coincident with UPDATE keeps PENDING; ACK on the valid cycle clears it.
        smin = 14'd1000; smax = 14'd1255;
        frame(N, 0, 1'b0);
        drive(1'b0, 1'b0, 1'b0);
        chk("ack_fp", fp, 1);
        repeat (14) drive(1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b1);
        chk("ack_gv", gv, 1);
        chk("ack_same_cycle_pend", pend, 1);
        chk("ack_gain", gain, IIR ? 99 : 16);
        drive(1'b0, 1'b0, 1'b0);
        chk("ack_later_pend", pend, 0);

        // Second frame ends while the first is still dividing.
        chk("ovr_before", ovr, 0);
        smin = 14'd1000; smax = 14'd1255;
        frame(N, 0, 1'b0);
        smax = 14'd1100;
        frame(N, 0, 1'b0);
        n = -1000; lat = -1; gv_cnt = 0; fp_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            drive(1'b0, 1'b0, 1'b0);
            if (fp) begin n = 0; fp_cnt++; end else n++;
            if (gv) begin gv_cnt++; lat = n; end
        end
        chk("ovr_fp_cnt", fp_cnt, 1);
        chk("ovr_gv_cnt", gv_cnt, 1);
        chk("ovr_lat", lat, 16);
        chk("ovr_gain", gain, IIR ? 84 : 40);
        chk("ovr_sticky", ovr, 1);

        // Asynchronous reset in the middle of a divide.
        frame(N, 0, 1'b0);
        drive(1'b0, 1'b0, 1'b0);
        chk("rstdiv_fp", fp, 1);
        repeat (7) drive(1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rstdiv_gain", gain, 16);
        chk("rstdiv_gv", gv, 0);
        chk("rstdiv_ovr", ovr, 0);
        chk("rstdiv_pend", pend, 0);
        repeat (2) drive(1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        gv_cnt = 0;
        repeat (20) begin
            drive(1'b0, 1'b0, 1'b0);
            if (gv) gv_cnt++;
        end
        chk("rstdiv_no_gv", gv_cnt, 0);

        // Randomized frames, aborts, stray strobes, ACKs and statistics.
        for (int it = 0; it < 80; it++) begin
            mn = $urandom_range(16383, 0);
            case ($urandom_range(3, 0))
                0:       mx = mn;
                1:       mx = mn + $urandom_range(300, 1);
                2:       mx = $urandom_range(16383, 0);
                default: mx = mn + $urandom_range(4, 1);
            endcase
            if (mx > 16383) mx = 16383;
            smin = 14'(mn); smax = 14'(mx);
            if ($urandom_range(4, 0) == 0) frame($urandom_range(N - 1, 1), 1, 1'b1);
            frame(N, $urandom_range(1, 0), 1'b1);
            repeat ($urandom_range(25, 0)) drive(1'b0, 1'($urandom_range(1, 0)), rbit(1'b1));
        end
        repeat (30) drive(1'b0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired actual=running expected=finished");
        $fatal(1, "watchdog");
    end
endmodule
